// File: rtl/add1_rr_sched_pkg.sv
// Shared FSM encodings and default sizing for the round-robin add-one scheduler.
package add1_rr_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam int WL_DEF   = 8;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;

endpackage

// File: rtl/add1_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IDW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add1_rr_sched.sv
// Round-robin scheduler sharing one signed add-one datapath among NREQ requesters.
// Define ADD1_SCHED_SAT_EN to saturate at the max positive value instead of wrapping.
module add1_rr_sched
    import add1_rr_sched_pkg::*;
#(
    parameter int WL   = WL_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic [NREQ-1:0]      I_REQ,
    input  logic [NREQ*WL-1:0]   I_DATA,
    output logic [NREQ-1:0]      O_GNT,
    output logic                 O_VLD,
    output logic [IDW-1:0]       O_ID,
    output logic signed [WL-1:0] O_DATA,
    input  logic                 I_RDY
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    function automatic logic signed [WL-1:0] inc_sat(input logic signed [WL-1:0] a);
        logic signed [WL-1:0] one;
        one = {{(WL-1){1'b0}}, 1'b1};
`ifdef ADD1_SCHED_SAT_EN
        if (a == {1'b0, {(WL-1){1'b1}}}) return a;
`endif
        return a + one;
    endfunction

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [NREQ-1:0]      pick_gnt;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;
    logic                 start;
    logic signed [WL-1:0] sel_data;
    logic signed [WL-1:0] opnd_p0;
    logic [IDW-1:0]       id_p0;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req (I_REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign sel_data = I_DATA[pick_idx*WL +: WL];
    // A grant can start from idle, or from a result being drained this same edge.
    assign start = pick_any && ((state == S_IDLE) || (state == S_VALID && I_RDY));

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state  <= S_IDLE;
            ptr    <= '0;
            O_GNT  <= '0;
            O_VLD  <= 1'b0;
            O_ID   <= '0;
            O_DATA <= '0;
        end else begin
            O_GNT <= '0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_EXEC;
                end
                S_EXEC: begin
                    O_DATA <= inc_sat(opnd_p0);
                    O_ID   <= id_p0;
                    O_VLD  <= 1'b1;
                    state  <= S_VALID;
                end
                S_VALID: begin
                    if (I_RDY) begin
                        O_VLD <= 1'b0;
                        state <= start ? S_EXEC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (start) begin
                O_GNT <= pick_gnt;
                ptr   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    // p0: operand and tag captured at grant time
    always_ff @(posedge I_CLK) begin
        if (start) begin
            opnd_p0 <= sel_data;
            id_p0   <= pick_idx;
        end
    end

endmodule

// File: tb/tb_add1_rr_sched.sv
// Directed self-checking bench for add1_rr_sched (WL=8, NREQ=4).
module tb_add1_rr_sched;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [31:0]       data;
    logic [3:0]        gnt;
    logic              vld;
    logic [1:0]        id;
    logic signed [7:0] o_data;
    logic              rdy;

    int n_checks = 0;
    int n_errors = 0;

    add1_rr_sched #(.WL(8), .NREQ(4), .IDW(2)) dut (
        .I_CLK  (clk),
        .I_RST  (rst),
        .I_REQ  (req),
        .I_DATA (data),
        .O_GNT  (gnt),
        .O_VLD  (vld),
        .O_ID   (id),
        .O_DATA (o_data),
        .I_RDY  (rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [7:0] v);
        data[k*8 +: 8] = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},  32'(gnt), 32'd0);
        check({tag, "_vld"},  32'(vld), 32'd0);
        check({tag, "_id"},   32'(id), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
    endtask

    // One isolated transaction with rdy high: grant, result, drain.
    task automatic run_one(input string tag, input int k, input logic [7:0] op,
                           input logic signed [7:0] exp_v);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        set_op(k, op);
        req = onehot;
        rdy = 1'b1;
        tick;
        check({tag, "_gnt"}, 32'(gnt), 32'(onehot));
        check({tag, "_vld0"}, 32'(vld), 32'd0);
        req = 4'b0000;
        tick;
        check({tag, "_gntoff"}, 32'(gnt), 32'd0);
        check({tag, "_vld"}, 32'(vld), 32'd1);
        check({tag, "_id"}, 32'(id), 32'(k));
        check({tag, "_data"}, 32'(o_data), 32'(exp_v));
        tick;
        check({tag, "_drain"}, 32'(vld), 32'd0);
    endtask

    logic signed [7:0] exp_d;
    logic [7:0]        op8;

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;
        rdy  = 1'b0;
        #1;
        check_idle_outputs("rst_during");
        tick;
        tick;
        rst = 1'b0;
        tick;
        check_idle_outputs("rst_after");

        // 1: single request on requester 2
        run_one("single", 2, 8'd5, 8'sd6);

        // 2: fairness from a fresh pointer
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_op(k, 8'(10 * k));
        req = 4'b1111;
        rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick;
            check("fair_gnt", 32'(gnt), 32'(4'b0001 << (n % 4)));
            tick;
            check("fair_vld", 32'(vld), 32'd1);
            check("fair_id", 32'(id), 32'(n % 4));
            check("fair_data", 32'(o_data), 32'(8'(10 * (n % 4) + 1)));
        end
        req = 4'b0000;
        tick;
        check("fair_drain", 32'(vld), 32'd0);

        // 3: backpressure; ptr is now 1, requester 3 waits behind the stall
        set_op(1, 8'hF9);
        set_op(3, 8'd20);
        req = 4'b0010;
        rdy = 1'b0;
        tick;
        check("bp_gnt", 32'(gnt), 32'b0010);
        req = 4'b1000;
        tick;
        for (int n = 0; n < 5; n++) begin
            check("bp_vld", 32'(vld), 32'd1);
            check("bp_id", 32'(id), 32'd1);
            check("bp_data", 32'(o_data), 32'(-8'sd6));
            check("bp_gnt0", 32'(gnt), 32'd0);
            tick;
        end
        rdy = 1'b1;
        check("bp_hold_last", 32'(vld), 32'd1);
        tick;
        check("bp_rel_gnt", 32'(gnt), 32'b1000);
        check("bp_rel_vld", 32'(vld), 32'd0);
        req = 4'b0000;
        tick;
        check("bp_next_id", 32'(id), 32'd3);
        check("bp_next_data", 32'(o_data), 32'd21);
        tick;
        check("bp_drain", 32'(vld), 32'd0);

        // 4: wrap / saturation boundaries
`ifdef ADD1_SCHED_SAT_EN
        run_one("max", 0, 8'd127, 8'sd127);
`else
        run_one("max", 0, 8'd127, -8'sd128);
`endif
        run_one("neg1", 2, 8'hFF, 8'sd0);
        run_one("min", 3, 8'h80, -8'sd127);

        // 5: reset while a result is pending; ptr would otherwise be 3
        set_op(2, 8'd3);
        req = 4'b0100;
        rdy = 1'b0;
        tick;
        req = 4'b0000;
        tick;
        check("rmid_pre_vld", 32'(vld), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rmid_async");
        tick;
        check_idle_outputs("rmid_hold");
        rst = 1'b0;
        rdy = 1'b1;
        set_op(1, 8'd40);
        set_op(3, 8'd50);
        req = 4'b1010;
        tick;
        check("rmid_gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick;
        check("rmid_id", 32'(id), 32'd1);
        check("rmid_data", 32'(o_data), 32'd41);
        tick;

        // 6: operand sweep on requester 1
        for (int v = 0; v < 256; v++) begin
            op8 = 8'(v);
            exp_d = 8'(v + 1);
`ifdef ADD1_SCHED_SAT_EN
            if (v == 127) exp_d = 8'sd127;
`endif
            run_one("sweep", 1, op8, exp_d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
